// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder slice.
//   WORD_W       : data word width (32)
//   BE_W         : byte-enable width (4)
//   dmem_state_t : responder FSM states IDLE / WAIT / RESP
//   cnt_width()  : width of the wait counter for a given latency (min 1 bit)
// Optional feature macro used by this slice: DMEM_ERR_EN (address error decode).
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // A zero-latency build still needs a 1-bit counter so the vector is legal.
    function automatic int cnt_width(input int latency);
        return (latency > 0) ? $clog2(latency + 1) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit word storage with per-byte write enables and a registered
// read port. Both the write and the read happen on the commit edge.
// The storage itself is never cleared; only the read register is reset.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-low reset (clears rdata only)
//   commit    in   commit strobe for this edge
//   byte_we   in   per-byte write enables (all zero for reads/suppressed writes)
//   rd_en     in   1 = load array word into rdata, 0 = load zero
//   word_addr in   word index
//   wdata     in   write data
//   rdata     out  registered read data
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit,
    input  logic [BE_W-1:0]   byte_we,
    input  logic              rd_en,
    input  logic [AW-1:0]     word_addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    // Storage write: only the enabled byte lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byte_we[i]) begin
                    mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value between commits; writes and suppressed
    // accesses present zero.
    always_comb begin
        rdata_d = rdata_q;
        if (commit) begin
            rdata_d = rd_en ? mem[word_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side end of a handshaked load/store port. Accepts one request at a
// time, waits LATENCY cycles, then commits the access and pulses ack for one
// cycle with registered read data.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-low reset
//   req    in   request valid (held stable by the initiator until ack)
//   we     in   1 = write, 0 = read
//   addr   in   byte address; word index = addr[$clog2(DEPTH)+1:2]
//   wdata  in   write data
//   be     in   write byte enables
//   busy   out  high whenever the FSM is not idle
//   ack    out  one-cycle completion pulse
//   rdata  out  read data (zero for writes / errored accesses)
//   err    out  access error, valid with ack
// Macro DMEM_ERR_EN: when defined, misaligned or out-of-range addresses
// complete with err=1 and have no side effects; when undefined err stays 0
// and addresses alias modulo 4*DEPTH.
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              busy,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam int                AW      = $clog2(DEPTH);
    localparam int                CNT_W   = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0]  LAT_CNT = CNT_W'(LATENCY);

    dmem_state_t       state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              we_d, we_q;
    logic [AW-1:0]     word_d, word_q;
    logic [WORD_W-1:0] wdata_d, wdata_q;
    logic [BE_W-1:0]   be_d, be_q;
    logic              aerr_d, aerr_q;
    logic              ack_d, ack_q;
    logic              busy_d, busy_q;
    logic              err_d, err_q;

    logic              req_err;
    logic              commit;
    logic              c_we;
    logic [AW-1:0]     c_word;
    logic [WORD_W-1:0] c_wdata;
    logic [BE_W-1:0]   c_be;
    logic              c_err;

    // Address error decode on the live request; it is latched with the rest
    // of the request so later address changes cannot affect it.
`ifdef DMEM_ERR_EN
    assign req_err = (addr[1:0] != 2'b00) || (addr[WORD_W-1:AW+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[WORD_W-1:AW+2], addr[1:0]};
    assign req_err          = 1'b0;
`endif

    // Next-state logic. The commit operands come from the latch, except for
    // a zero-latency access which commits on its own acceptance edge and so
    // must use the live inputs. Reset suppresses the commit so an aborted
    // transaction can never write the array.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        aerr_d  = aerr_q;
        commit  = 1'b0;
        c_we    = we_q;
        c_word  = word_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        c_err   = aerr_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    word_d  = addr[AW+1:2];
                    wdata_d = wdata;
                    be_d    = be;
                    aerr_d  = req_err;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                        c_we    = we;
                        c_word  = addr[AW+1:2];
                        c_wdata = wdata;
                        c_be    = be;
                        c_err   = req_err;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAT_CNT) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ack_d  = commit;
        busy_d = (state_d != IDLE);
        err_d  = commit ? c_err : err_q;

        if (!reset) begin
            commit = 1'b0;
        end
    end

    // FSM, counter, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            aerr_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            aerr_q  <= aerr_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .reset     (reset),
        .commit    (commit),
        .byte_we   ((c_we && !c_err) ? c_be : '0),
        .rd_en     (!c_we && !c_err),
        .word_addr (c_word),
        .wdata     (c_wdata),
        .rdata     (rdata)
    );

    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule
